toll_lane_ctrl: RTL and testbench
=================================

# toll_lane_ctrl

Sequencer for one toll lane. It tracks a vehicle through the three lane sensors and decides whether to open the barrier, either from the E-pass reader verdict or from a manual `enable`. It sits between the raw lane inputs and the barrier output in `top`, alongside the speed datapath. It also emits one-entry event records that the UART reporter serialises.

## Interface
- `SYS_FREQ`, 10000000, clock frequency in Hz; the 1 ms tick period is `SYS_FREQ/1000` cycles.
- `EPASS_WAIT_MS`, 200, how long CHECK waits for a reader verdict.
- `OPEN_TIMEOUT_MS`, 5000, maximum time the barrier stays open without sensor3 activity.
- `WIDTH_MS`, 13, width of the ms timer; must hold `max(EPASS_WAIT_MS, OPEN_TIMEOUT_MS)`.
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `sensor1` / `sensor2` / `sensor3` in 1 each: lane entry, reader position, and exit presence; asynchronous, high = occupied.
- `valid_Epass` in 2: reader verdict. 00 = none, 10 = valid, 01 = insufficient, 11 = treated as 01.
- `enable` in 1: manual payment or operator open, level-sensitive.
- `barrier` out 1: 1 = open.
- `busy` out 1: high in any state other than IDLE.
- `evt_valid` out 1: an event record is pending.
- `evt_code` out 3: event code. 1 EPASS_OPEN, 2 MANUAL_OPEN, 3 PASSED, 4 ABORT, 5 TIMEOUT.
- `evt_ready` in 1: the reporter accepts the record.
- `evt_drop` out 1: sticky; set when an event is lost; cleared only by reset.

## Operation
- **Input conditioning:** every sensor, `valid_Epass` bit and `enable` passes through a 2-flop synchroniser. The FSM uses only the synchronised copies, plus rise/fall pulses derived from the second flop.
- **ms tick:** a free-running prescaler produces a one-cycle `tick` every `SYS_FREQ/1000` cycles. The ms timer clears on every state entry and increments on `tick`, saturating at its maximum.
- **FSM states:** IDLE, ARRIVE, CHECK, WAIT_PAY, OPEN, PASSING.
  - **IDLE → ARRIVE** on sensor1 rise.
  - **ARRIVE:**
    - → CHECK on sensor2 rise.
    - → IDLE if sensor1 falls while sensor2 = 0, with no event.
  - **CHECK:**
    - valid_Epass = 10 → OPEN, EPASS_OPEN.
    - Otherwise `enable` = 1 → OPEN, MANUAL_OPEN.
    - valid_Epass = 01 or 11 → WAIT_PAY.
    - Timer ≥ EPASS_WAIT_MS → WAIT_PAY.
    - Priority is valid-pass > enable > insufficient > timeout.
  - **WAIT_PAY:**
    - `enable` = 1 → OPEN, MANUAL_OPEN.
    - valid_Epass = 10 → OPEN, EPASS_OPEN.
    - sensor1 = 0 and sensor2 = 0 → IDLE, ABORT.
  - **OPEN:**
    - sensor3 rise → PASSING.
    - Timer ≥ OPEN_TIMEOUT_MS → IDLE, TIMEOUT.
  - **PASSING:** sensor3 fall → IDLE, PASSED.
- **Ignored inputs:** sensor3 activity in IDLE, ARRIVE, CHECK and WAIT_PAY has no effect. `enable` and `valid_Epass` in IDLE, ARRIVE, OPEN and PASSING have no effect.
- **Barrier:** a registered output, 1 exactly while the state is OPEN or PASSING.
- **Event register:** a single entry.
  - A new event loads the register when it is empty, or in the same cycle as `evt_valid & evt_ready`.
  - Otherwise the new event is discarded and `evt_drop` is set. The pending record is never overwritten.
  - `evt_valid` clears on `evt_ready` when no new event arrives in that cycle.

## Timing
- **Reset values:** `barrier`=0, `busy`=0, `evt_valid`=0, `evt_code`=0, `evt_drop`=0, state IDLE, prescaler and timer 0.
- **Reset mid-operation:** `reset_n` low closes the barrier asynchronously and abandons any pending event.
- **Pin-to-state latency:** 3 cycles. Two synchroniser cycles plus one state-register cycle, counted from the input change to the new state.
- **Barrier change:** visible in the same edge as the state register; 3 cycles after the triggering pin.
- **Event timing:** `evt_valid` rises on the same edge that commits the transition producing the event.
- **Handshake:** valid/ready. Transfer occurs when both are high on a rising edge, and `evt_code` is held stable while `evt_valid` is high.
- **Timeout resolution:** 1 ms. A timeout fires on the tick that makes timer = limit; jitter is at most one tick period.
- **Simultaneous events:** sensor2 rise together with sensor1 fall in ARRIVE goes to CHECK.

## Structure
- **Package `toll_pkg`:** state encoding, event codes (EVT_EPASS_OPEN … EVT_TIMEOUT), and valid_Epass codes (EP_NONE=00, EP_VALID=10, EP_LOW=01).
- **Sub-module `ms_tick_gen`:** parameterised by `SYS_FREQ`; outputs a one-cycle `tick`. It is shared with the speed datapath.

## Test plan
Every scenario runs with `SYS_FREQ`=10000, so 1 ms = 10 cycles.
- **E-pass pass:** sensor1↑, sensor2↑, valid_Epass=10 after 5 ms, sensor3↑ then ↓.
  - barrier=1 3 cycles after the verdict; EPASS_OPEN, then PASSED; barrier=0 3 cycles after sensor3↓.
- **Manual pay:** valid_Epass=01 in CHECK, then enable=1 after 50 ms.
  - Goes to WAIT_PAY, then OPEN; a single MANUAL_OPEN event.
- **Reader silent and vehicle reverses:** no verdict for 200 ms, then sensor1 and sensor2 fall.
  - WAIT_PAY at 200 ms; ABORT event; barrier stays 0 throughout.
- **Open timeout:** OPEN with no sensor3 for 5000 ms.
  - TIMEOUT event; barrier=0 within one tick of 5000 ms.
- **Event backpressure:** hold `evt_ready`=0 through two events.
  - The first event's code is retained; `evt_drop`=1; when `evt_ready` rises, one transfer then `evt_valid`=0.
- **Async reset:** `reset_n`=0 in PASSING with `evt_valid`=1.
  - barrier=0 with no clock edge; all outputs at their reset values.

Source files
------------

// File: rtl/toll_pkg.sv
// toll_pkg: shared state encoding, event codes and reader verdict codes for the toll lane
package toll_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARRIVE,
        S_CHECK,
        S_WAIT_PAY,
        S_OPEN,
        S_PASSING
    } state_t;

    typedef enum logic [2:0] {
        EVT_NONE        = 3'd0,
        EVT_EPASS_OPEN  = 3'd1,
        EVT_MANUAL_OPEN = 3'd2,
        EVT_PASSED      = 3'd3,
        EVT_ABORT       = 3'd4,
        EVT_TIMEOUT     = 3'd5
    } evt_t;

    localparam logic [1:0] EP_NONE  = 2'b00;
    localparam logic [1:0] EP_VALID = 2'b10;
    localparam logic [1:0] EP_LOW   = 2'b01;
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: free-running prescaler emitting a one-cycle tick every SYS_FREQ/1000 cycles
// Ports: clk, reset_n (async active-low), tick (one-cycle pulse per ms)
module ms_tick_gen #(
    parameter int SYS_FREQ = 10000000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int DIV = SYS_FREQ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else          cnt <= tick ? '0 : cnt + CW'(1);
endmodule

// File: rtl/toll_lane_ctrl.sv
// toll_lane_ctrl: toll lane sequencer driving the barrier and emitting one-entry event records
// Ports: clk, reset_n (async active-low); sensor1/2/3, valid_Epass, enable (async lane inputs);
//        barrier, busy (status); evt_valid/evt_code/evt_ready (event handshake); evt_drop (sticky loss flag)
module toll_lane_ctrl
    import toll_pkg::*;
#(
    parameter int SYS_FREQ        = 10000000,
    parameter int EPASS_WAIT_MS   = 200,
    parameter int OPEN_TIMEOUT_MS = 5000,
    parameter int WIDTH_MS        = 13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor1,
    input  logic       sensor2,
    input  logic       sensor3,
    input  logic [1:0] valid_Epass,
    input  logic       enable,
    output logic       barrier,
    output logic       busy,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_drop
);
    localparam logic [WIDTH_MS-1:0] EPASS_LIM = WIDTH_MS'(EPASS_WAIT_MS);
    localparam logic [WIDTH_MS-1:0] OPEN_LIM  = WIDTH_MS'(OPEN_TIMEOUT_MS);

    // bit map: [0] sensor1, [1] sensor2, [2] sensor3, [4:3] valid_Epass, [5] enable
    logic [5:0] sync1, sync2;
    logic [2:0] prev;
    logic       tick;
    logic [WIDTH_MS-1:0] timer;
    state_t     state, next;
    logic       evt_new;
    evt_t       evt_new_code;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {enable, valid_Epass, sensor3, sensor2, sensor1};
            sync2 <= sync1;
            prev  <= sync2[2:0];
        end

    wire s1      = sync2[0];
    wire s2      = sync2[1];
    wire [1:0] ep = sync2[4:3];
    wire en      = sync2[5];
    wire s1_rise = sync2[0] & ~prev[0];
    wire s1_fall = ~sync2[0] & prev[0];
    wire s2_rise = sync2[1] & ~prev[1];
    wire s3_rise = sync2[2] & ~prev[2];
    wire s3_fall = ~sync2[2] & prev[2];

    ms_tick_gen #(.SYS_FREQ(SYS_FREQ)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    always_comb begin
        next         = state;
        evt_new      = 1'b0;
        evt_new_code = EVT_NONE;
        case (state)
            S_IDLE:
                if (s1_rise) next = S_ARRIVE;
            S_ARRIVE:
                // a simultaneous sensor2 rise wins over the sensor1 fall
                if (s2_rise)           next = S_CHECK;
                else if (s1_fall && !s2) next = S_IDLE;
            S_CHECK:
                if (ep == EP_VALID) begin
                    next = S_OPEN; evt_new = 1'b1; evt_new_code = EVT_EPASS_OPEN;
                end else if (en) begin
                    next = S_OPEN; evt_new = 1'b1; evt_new_code = EVT_MANUAL_OPEN;
                end else if (ep[0] || timer >= EPASS_LIM) begin
                    // 01 and 11 both mean insufficient balance
                    next = S_WAIT_PAY;
                end
            S_WAIT_PAY:
                if (en) begin
                    next = S_OPEN; evt_new = 1'b1; evt_new_code = EVT_MANUAL_OPEN;
                end else if (ep == EP_VALID) begin
                    next = S_OPEN; evt_new = 1'b1; evt_new_code = EVT_EPASS_OPEN;
                end else if (!s1 && !s2) begin
                    next = S_IDLE; evt_new = 1'b1; evt_new_code = EVT_ABORT;
                end
            S_OPEN:
                if (s3_rise) next = S_PASSING;
                else if (timer >= OPEN_LIM) begin
                    next = S_IDLE; evt_new = 1'b1; evt_new_code = EVT_TIMEOUT;
                end
            S_PASSING:
                if (s3_fall) begin
                    next = S_IDLE; evt_new = 1'b1; evt_new_code = EVT_PASSED;
                end
            default: next = S_IDLE;
        endcase
    end

    assign busy = state != S_IDLE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            barrier <= 1'b0;
        end else begin
            state   <= next;
            timer   <= (next != state) ? '0 : (tick && timer != '1) ? timer + WIDTH_MS'(1) : timer;
            barrier <= next == S_OPEN || next == S_PASSING;
        end

    // single-entry record: a pending event is never overwritten, a lost one sets evt_drop
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_drop  <= 1'b0;
        end else if (evt_new && (!evt_valid || evt_ready)) begin
            evt_valid <= 1'b1;
            evt_code  <= evt_new_code;
        end else begin
            if (evt_new)   evt_drop  <= 1'b1;
            if (evt_ready) evt_valid <= 1'b0;
        end
endmodule

// File: tb/tb_toll_lane_ctrl.sv
// tb_toll_lane_ctrl: directed self-checking bench for toll_lane_ctrl at 1 ms = 10 cycles
module tb_toll_lane_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor1 = 1'b0, sensor2 = 1'b0, sensor3 = 1'b0;
    logic [1:0] valid_Epass = 2'b00;
    logic       enable = 1'b0;
    logic       barrier, busy, evt_valid, evt_drop;
    logic [2:0] evt_code;
    logic       evt_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    toll_lane_ctrl #(.SYS_FREQ(10000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .sensor3     (sensor3),
        .valid_Epass (valid_Epass),
        .enable      (enable),
        .barrier     (barrier),
        .busy        (busy),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_drop    (evt_drop)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #2;
        checks++; if ({barrier, busy, evt_valid, evt_code, evt_drop} !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b want 0000000", {barrier, busy, evt_valid, evt_code, evt_drop}); end
        @(negedge clk);
        reset_n = 1'b1;
        cyc(5);
        checks++; if ({barrier, busy, evt_valid} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b want 000", {barrier, busy, evt_valid}); end
    endtask

    task automatic test_epass;
        sensor1 = 1'b1; cyc(4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL epass_arrive_busy got %b want 1", busy); end
        sensor2 = 1'b1; cyc(4);
        cyc(50);
        valid_Epass = 2'b10; cyc(2);
        checks++; if (barrier !== 1'b0) begin errors++; $display("FAIL epass_barrier_early got %b want 0", barrier); end
        cyc(1);
        checks++; if (barrier !== 1'b1) begin errors++; $display("FAIL epass_barrier_open got %b want 1", barrier); end
        checks++; if ({evt_valid, evt_code} !== 4'b1_001) begin errors++; $display("FAIL epass_evt got %b want 1001", {evt_valid, evt_code}); end
        valid_Epass = 2'b00;
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL epass_evt_consumed got %b want 0", evt_valid); end
        sensor3 = 1'b1; cyc(4);
        sensor1 = 1'b0; sensor2 = 1'b0; cyc(4);
        checks++; if ({barrier, evt_valid} !== 2'b10) begin errors++; $display("FAIL epass_passing got %b want 10", {barrier, evt_valid}); end
        sensor3 = 1'b0; cyc(2);
        checks++; if (barrier !== 1'b1) begin errors++; $display("FAIL epass_barrier_hold got %b want 1", barrier); end
        cyc(1);
        checks++; if ({barrier, busy, evt_valid, evt_code} !== 6'b0_0_1_011) begin errors++; $display("FAIL epass_passed got %b want 001011", {barrier, busy, evt_valid, evt_code}); end
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    endtask

    task automatic test_manual;
        sensor1 = 1'b1; cyc(4);
        sensor2 = 1'b1; cyc(4);
        valid_Epass = 2'b01; cyc(3);
        checks++; if ({busy, barrier, evt_valid} !== 3'b100) begin errors++; $display("FAIL manual_wait_pay got %b want 100", {busy, barrier, evt_valid}); end
        valid_Epass = 2'b00; cyc(500);
        checks++; if ({busy, barrier, evt_valid} !== 3'b100) begin errors++; $display("FAIL manual_still_waiting got %b want 100", {busy, barrier, evt_valid}); end
        enable = 1'b1; cyc(3);
        checks++; if ({barrier, evt_valid, evt_code} !== 5'b1_1_010) begin errors++; $display("FAIL manual_open got %b want 11010", {barrier, evt_valid, evt_code}); end
        enable = 1'b0;
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        cyc(20);
        checks++; if ({barrier, evt_valid} !== 2'b10) begin errors++; $display("FAIL manual_single_event got %b want 10", {barrier, evt_valid}); end
        sensor3 = 1'b1; cyc(4);
        sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b0; cyc(3);
        checks++; if ({barrier, evt_valid, evt_code} !== 5'b0_1_011) begin errors++; $display("FAIL manual_passed got %b want 01011", {barrier, evt_valid, evt_code}); end
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    endtask

    task automatic test_silent_reverse;
        sensor1 = 1'b1; cyc(4);
        sensor2 = 1'b1; cyc(4);
        cyc(1890);
        sensor1 = 1'b0; sensor2 = 1'b0; cyc(10);
        checks++; if ({busy, barrier, evt_valid} !== 3'b100) begin errors++; $display("FAIL silent_check_ignores_leave got %b want 100", {busy, barrier, evt_valid}); end
        cyc(200);
        checks++; if ({busy, barrier, evt_valid, evt_code} !== 6'b0_0_1_100) begin errors++; $display("FAIL silent_abort got %b want 001100", {busy, barrier, evt_valid, evt_code}); end
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
    endtask

    task automatic test_open_timeout;
        sensor1 = 1'b1; cyc(4);
        sensor2 = 1'b1; cyc(4);
        valid_Epass = 2'b10; cyc(3);
        valid_Epass = 2'b00;
        checks++; if ({barrier, evt_code} !== 4'b1_001) begin errors++; $display("FAIL timeout_open got %b want 1001", {barrier, evt_code}); end
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        cyc(49978);
        checks++; if ({barrier, evt_valid} !== 2'b10) begin errors++; $display("FAIL timeout_before_limit got %b want 10", {barrier, evt_valid}); end
        cyc(40);
        checks++; if ({barrier, busy, evt_valid, evt_code} !== 6'b0_0_1_101) begin errors++; $display("FAIL timeout_event got %b want 001101", {barrier, busy, evt_valid, evt_code}); end
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        sensor1 = 1'b0; sensor2 = 1'b0; cyc(5);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_stays_idle got %b want 0", busy); end
    endtask

    task automatic test_backpressure;
        checks++; if (evt_drop !== 1'b0) begin errors++; $display("FAIL bp_drop_before got %b want 0", evt_drop); end
        sensor1 = 1'b1; cyc(4);
        sensor2 = 1'b1; cyc(4);
        enable = 1'b1; cyc(3);
        enable = 1'b0;
        checks++; if ({evt_valid, evt_code} !== 4'b1_010) begin errors++; $display("FAIL bp_first_event got %b want 1010", {evt_valid, evt_code}); end
        sensor3 = 1'b1; cyc(4);
        sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b0; cyc(4);
        checks++; if ({busy, evt_valid, evt_code, evt_drop} !== 6'b0_1_010_1) begin errors++; $display("FAIL bp_retained_dropped got %b want 010101", {busy, evt_valid, evt_code, evt_drop}); end
        evt_ready = 1'b1; cyc(1); evt_ready = 1'b0;
        checks++; if ({evt_valid, evt_drop} !== 2'b01) begin errors++; $display("FAIL bp_one_transfer got %b want 01", {evt_valid, evt_drop}); end
        cyc(3);
        checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL bp_no_second got %b want 0", evt_valid); end
    endtask

    task automatic test_async_reset;
        sensor1 = 1'b1; cyc(4);
        sensor2 = 1'b1; cyc(4);
        valid_Epass = 2'b10; cyc(3);
        valid_Epass = 2'b00;
        sensor3 = 1'b1; cyc(4);
        checks++; if ({barrier, busy, evt_valid} !== 3'b111) begin errors++; $display("FAIL arst_passing got %b want 111", {barrier, busy, evt_valid}); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({barrier, busy, evt_valid, evt_code, evt_drop} !== 7'b0) begin errors++; $display("FAIL arst_outputs got %b want 0000000", {barrier, busy, evt_valid, evt_code, evt_drop}); end
        sensor1 = 1'b0; sensor2 = 1'b0; sensor3 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1; cyc(5);
        checks++; if ({barrier, busy, evt_valid} !== 3'b000) begin errors++; $display("FAIL arst_idle_after got %b want 000", {barrier, busy, evt_valid}); end
    endtask

    initial begin
        test_reset;
        test_epass;
        test_manual;
        test_silent_reverse;
        test_open_timeout;
        test_backpressure;
        test_async_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
